// File: rtl/pws_pkg.sv
// Shared definitions for the pixel write scheduler: state encoding,
// colour constants and coordinate widths for the 160x120 frame.
package pws_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    P1_SWEEP,
    P2_SWEEP,
    BALL_ERASE,
    BALL_DRAW,
    DONE
  } state_t;

  // States in which one pixel is written every cycle.
  function automatic logic is_walk(input state_t s);
    return (s == P1_SWEEP) || (s == P2_SWEEP) ||
           (s == BALL_ERASE) || (s == BALL_DRAW);
  endfunction

endpackage

// File: rtl/pws_rect_walker.sv
// Raster walker over a w x h rectangle, dx as the inner coordinate.
// nx/ny expose the coordinate that becomes current on the next edge so
// the caller can register its pixel outputs in the same cycle.
module pws_rect_walker
  import pws_pkg::*;
#(
  parameter int C_W = Y_W
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           start,
  input  logic           step,
  input  logic [C_W-1:0] w,
  input  logic [C_W-1:0] h,
  output logic [C_W-1:0] nx,
  output logic [C_W-1:0] ny,
  output logic           last
);

  logic [C_W-1:0] dx;
  logic [C_W-1:0] dy;

  // Next coordinate: restart at the origin, or advance in raster order.
  always_comb begin
    nx = dx;
    ny = dy;
    if (start) begin
      nx = '0;
      ny = '0;
    end else if (step) begin
      if (dx == w - 1'b1) begin
        nx = '0;
        ny = (dy == h - 1'b1) ? '0 : dy + 1'b1;
      end else begin
        nx = dx + 1'b1;
      end
    end
  end

  // Coordinate register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dx <= '0;
      dy <= '0;
    end else begin
      dx <= nx;
      dy <= ny;
    end
  end

  assign last = (dx == w - 1'b1) && (dy == h - 1'b1);

endmodule

// File: rtl/pixel_write_scheduler.sv
// Sole writer of the VGA adapter pixel port. Each frame tick latches the
// paddle and ball positions and repaints both paddle columns top to bottom,
// then (with PWS_BALL_EN defined) erases the old ball and draws the new one.
// Without PWS_BALL_EN the ball phases are absent and ball_x/ball_y are ignored.
module pixel_write_scheduler
  import pws_pkg::*;
#(
  parameter int         SCREEN_H  = 120,
  parameter int         PADDLE_H  = 12,
  parameter int         P1_X      = 0,
  parameter int         P2_X      = 159,
  parameter int         BALL_SIZE = 2,
  parameter logic [2:0] FG_COLOUR = WHITE,
  parameter logic [2:0] BG_COLOUR = BLACK
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           frame_tick,
  input  logic [Y_W-1:0] p1_y,
  input  logic [Y_W-1:0] p2_y,
  input  logic [X_W-1:0] ball_x,
  input  logic [Y_W-1:0] ball_y,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     colour,
  output logic           plot,
  output logic           busy,
  output logic           done,
  output logic           overrun
);

  localparam logic [Y_W-1:0] ROWS   = Y_W'(SCREEN_H);
  localparam logic [Y_W-1:0] PY_MAX = Y_W'(SCREEN_H - PADDLE_H);
  localparam logic [7:0]     PH8    = 8'(PADDLE_H);
  localparam logic [X_W-1:0] P1_COL = X_W'(P1_X);
  localparam logic [X_W-1:0] P2_COL = X_W'(P2_X);
`ifdef PWS_BALL_EN
  localparam logic [Y_W-1:0] BSZ    = Y_W'(BALL_SIZE);
  localparam logic [Y_W-1:0] BY_MAX = Y_W'(SCREEN_H - BALL_SIZE);
  localparam logic [X_W-1:0] BX_MAX = X_W'(160 - BALL_SIZE);
`else
  localparam int unused_ball_size = BALL_SIZE;
`endif

  function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] v,
                                             input logic [Y_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

`ifdef PWS_BALL_EN
  function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] v,
                                             input logic [X_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction
`endif

  // Row sums are widened to 8 bits so py+PADDLE_H never wraps.
  function automatic logic in_paddle(input logic [Y_W-1:0] r,
                                     input logic [Y_W-1:0] top);
    logic [7:0] r8;
    logic [7:0] t8;
    r8 = {1'b0, r};
    t8 = {1'b0, top};
    return (r8 >= t8) && (r8 < t8 + PH8);
  endfunction

  state_t         state, state_nxt;
  logic [Y_W-1:0] py1, py2, py1_n, py2_n;
  logic           start, step, last;
  logic [Y_W-1:0] w, h, nx, ny;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic [2:0]     colour_nxt;

  // Positions seen by the first pixel of each phase: fresh clamped inputs
  // while leaving LATCH, the held copy afterwards.
  assign py1_n = (state == LATCH) ? clamp_y(p1_y, PY_MAX) : py1;
  assign py2_n = (state == LATCH) ? clamp_y(p2_y, PY_MAX) : py2;

`ifdef PWS_BALL_EN
  logic [X_W-1:0] bx, bx_n, old_bx;
  logic [Y_W-1:0] by, by_n, old_by;
  assign bx_n = (state == LATCH) ? clamp_x(ball_x, BX_MAX) : bx;
  assign by_n = (state == LATCH) ? clamp_y(ball_y, BY_MAX) : by;
`else
  logic unused_ball;
  assign unused_ball = ^{ball_x, ball_y};
`endif

  // Next state, walker control and next registered pixel outputs.
  always_comb begin
    state_nxt  = state;
    x_nxt      = '0;
    y_nxt      = '0;
    colour_nxt = BG_COLOUR;
    w          = Y_W'(1);
    h          = ROWS;
    case (state)
      IDLE:       if (frame_tick) state_nxt = LATCH;
      LATCH:      state_nxt = P1_SWEEP;
      P1_SWEEP:   if (last) state_nxt = P2_SWEEP;
`ifdef PWS_BALL_EN
      P2_SWEEP:   if (last) state_nxt = BALL_ERASE;
      BALL_ERASE: if (last) state_nxt = BALL_DRAW;
      BALL_DRAW:  if (last) state_nxt = DONE;
`else
      P2_SWEEP:   if (last) state_nxt = DONE;
`endif
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
`ifdef PWS_BALL_EN
    if (state == BALL_ERASE || state == BALL_DRAW) begin
      w = BSZ;
      h = BSZ;
    end
`endif
    start = (state_nxt != state) && is_walk(state_nxt);
    step  = is_walk(state) && !last;
    case (state_nxt)
      P1_SWEEP: begin
        x_nxt      = P1_COL;
        y_nxt      = ny;
        colour_nxt = in_paddle(ny, py1_n) ? FG_COLOUR : BG_COLOUR;
      end
      P2_SWEEP: begin
        x_nxt      = P2_COL;
        y_nxt      = ny;
        colour_nxt = in_paddle(ny, py2_n) ? FG_COLOUR : BG_COLOUR;
      end
`ifdef PWS_BALL_EN
      BALL_ERASE: begin
        x_nxt      = old_bx + X_W'(nx);
        y_nxt      = old_by + ny;
        colour_nxt = BG_COLOUR;
      end
      BALL_DRAW: begin
        x_nxt      = bx_n + X_W'(nx);
        y_nxt      = by_n + ny;
        colour_nxt = FG_COLOUR;
      end
`endif
      default: ;
    endcase
  end

  pws_rect_walker #(.C_W(Y_W)) u_walker (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .step   (step),
    .w      (w),
    .h      (h),
    .nx     (nx),
    .ny     (ny),
    .last   (last)
  );

  // State register, registered pixel port and status flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state  <= state_nxt;
      x      <= x_nxt;
      y      <= y_nxt;
      colour <= colour_nxt;
      plot   <= is_walk(state_nxt);
      busy   <= (state_nxt != IDLE);
      done   <= (state_nxt == DONE);
      if (frame_tick && busy) overrun <= 1'b1;
    end
  end

  // Frame positions, refreshed as LATCH is left.
  always_ff @(posedge clock) begin
    py1 <= py1_n;
    py2 <= py2_n;
`ifdef PWS_BALL_EN
    bx  <= bx_n;
    by  <= by_n;
`endif
  end

`ifdef PWS_BALL_EN
  // Remember where the ball was drawn so the next frame can erase it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      old_bx <= '0;
      old_by <= '0;
    end else if (state == BALL_DRAW && last) begin
      old_bx <= bx;
      old_by <= by;
    end
  end
`endif

endmodule
